// File: rtl/spi_slave.sv
// SPI slave endpoint, one per chip-select line.
// Runs entirely in the sclk domain; all four CPOL/CPHA modes, MSB- or LSB-first,
// back-to-back words while cs_n stays low. Host handoff is via toggle flags and
// quasi-static data words.
module spi_slave #(
    parameter int unsigned NBITS = 8
) (
    input  logic             sclk,
    input  logic             reset,
    input  logic             cs_n,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    input  logic             cpol,
    input  logic             cpha,
    input  logic             lsb_first,
    input  logic [NBITS-1:0] tx_data,
    output logic             tx_taken_tgl,
    output logic [NBITS-1:0] rx_data,
    output logic             rx_tgl
);

    localparam int unsigned   CW   = $clog2(NBITS);
    localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

    // Mode-normalised clock: capture on its rising edge, launch on its falling edge.
    logic sclk_eff;
    // Transfer state is cleared by reset or by deselect.
    logic clr_n;

    assign sclk_eff = sclk ^ (cpol ^ cpha);
    assign clr_n    = reset & ~cs_n;

    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]    out_idx_q;
    logic [NBITS-1:0] rx_shift_q, rx_shift_d;
    logic [NBITS-1:0] tx_shadow_q;
    logic [NBITS-1:0] rx_data_q;
    logic             rx_tgl_q;
    logic             tx_taken_q;
    logic [CW-1:0]    pos;

    // Next bit counter and shifted receive word, including the bit being captured now.
    always_comb begin
        bit_cnt_d  = (bit_cnt_q == LAST) ? '0 : bit_cnt_q + 1'b1;
        rx_shift_d = lsb_first ? {mosi, rx_shift_q[NBITS-1:1]}
                               : {rx_shift_q[NBITS-2:0], mosi};
    end

    // Capture-edge transfer state, cleared whenever the slave is not selected.
    always_ff @(posedge sclk_eff or negedge clr_n) begin
        if (!clr_n) begin
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // Capture-edge host handoff; only reset clears it so words survive deselect.
    always_ff @(posedge sclk_eff or negedge reset) begin
        if (!reset) begin
            tx_shadow_q <= '0;
            tx_taken_q  <= 1'b0;
            rx_data_q   <= '0;
            rx_tgl_q    <= 1'b0;
        end else if (!cs_n) begin
            // Gate on cs_n so idle mode-pin changes cannot produce a phantom edge.
            if (bit_cnt_q == '0) begin
                tx_shadow_q <= tx_data;
                tx_taken_q  <= ~tx_taken_q;
            end
            if (bit_cnt_q == LAST) begin
                rx_data_q <= rx_shift_d;
                rx_tgl_q  <= ~rx_tgl_q;
            end
        end
    end

    // Launch edge: advance the output bit index to the count of bits captured so far.
    always_ff @(negedge sclk_eff or negedge clr_n) begin
        if (!clr_n) begin
            out_idx_q <= '0;
        end else begin
            out_idx_q <= bit_cnt_q;
        end
    end

    // Output mux: bit 0 of each word comes straight from tx_data so it is valid before
    // the first capture edge; later bits come from the latched shadow.
    always_comb begin
        pos     = lsb_first ? out_idx_q : LAST - out_idx_q;
        miso    = 1'b0;
        miso_oe = ~cs_n & reset;
        if (!cs_n && reset) begin
            miso = (out_idx_q == '0) ? tx_data[pos] : tx_shadow_q[pos];
        end
    end

    assign tx_taken_tgl = tx_taken_q;
    assign rx_data      = rx_data_q;
    assign rx_tgl       = rx_tgl_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: bit-banged SPI master plus a word-level model
// of what each side must receive and how often the toggles must flip.
module tb_spi_slave;

    localparam int N    = 8;
    localparam int HALF = 10;

    logic         sclk, reset, cs_n, mosi, miso, miso_oe, cpol, cpha, lsb_first;
    logic [N-1:0] tx_data, rx_data;
    logic         tx_taken_tgl, rx_tgl;

    spi_slave #(.NBITS(N)) dut (
        .sclk         (sclk),
        .reset        (reset),
        .cs_n         (cs_n),
        .mosi         (mosi),
        .miso         (miso),
        .miso_oe      (miso_oe),
        .cpol         (cpol),
        .cpha         (cpha),
        .lsb_first    (lsb_first),
        .tx_data      (tx_data),
        .tx_taken_tgl (tx_taken_tgl),
        .rx_data      (rx_data),
        .rx_tgl       (rx_tgl)
    );

    int checks = 0;
    int passed = 0;

    // Model: last completed word, completed-word count, words-started count.
    logic [N-1:0] exp_rx  = '0;
    int           exp_rxc = 0;
    int           exp_tk  = 0;

    logic [N-1:0] mo_a[4];
    logic [N-1:0] tx_a[4];
    logic [N-1:0] last_mi;

    logic [N-1:0] t2_mo[3] = '{8'h3C, 8'hF9, 8'h21};
    logic [N-1:0] t2_tx[3] = '{8'hE9, 8'hDB, 8'h48};
    logic [N-1:0] t3_mo[4] = '{8'h7B, 8'hE9, 8'hDB, 8'h48};
    logic [N-1:0] t3_tx[4] = '{8'hA5, 8'h3C, 8'hF9, 8'h21};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    endtask

    // Output-enable and idle-low MISO are checked every 5 time units, away from input changes.
    initial begin
        #2;
        forever begin
            check("miso_oe", {31'd0, miso_oe}, {31'd0, ~cs_n & reset});
            if (cs_n || !reset) check("miso_idle", {31'd0, miso}, 32'd0);
            #5;
        end
    end

    // Mode pins may only move while deselected.
    always @(cpol or cpha or lsb_first) check("mode_change_while_selected", {31'd0, cs_n}, 32'd1);

    task automatic check_state(input string tag);
        #2;
        check({tag, "_rx_data"}, {24'd0, rx_data}, {24'd0, exp_rx});
        check({tag, "_rx_tgl"}, {31'd0, rx_tgl}, {31'd0, exp_rxc[0]});
        check({tag, "_tx_taken_tgl"}, {31'd0, tx_taken_tgl}, {31'd0, exp_tk[0]});
        #3;
    endtask

    task automatic set_mode(input logic pol, input logic pha, input logic lsb);
        cpol      = pol;
        cpha      = pha;
        lsb_first = lsb;
        sclk      = pol;
        #HALF;
    endtask

    // Master side of one word: drives nb bits of mo, samples miso at each capture edge,
    // and swaps tx_data to the next word right after the first capture.
    task automatic xfer_word(input logic [N-1:0] mo, input logic [N-1:0] nxt_tx, input int nb,
                             output logic [N-1:0] mi);
        int b;
        mi = '0;
        for (int i = 0; i < nb; i++) begin
            b = lsb_first ? i : N - 1 - i;
            if (!cpha) begin
                mosi = mo[b];
                #HALF;
                mi[b] = miso;
                sclk  = ~cpol;
                #(HALF / 2);
                if (i == 0) tx_data = nxt_tx;
                #(HALF / 2);
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                #(HALF / 2);
                mosi = mo[b];
                #(HALF / 2);
                mi[b] = miso;
                sclk  = cpol;
                #(HALF / 2);
                if (i == 0) tx_data = nxt_tx;
                #(HALF / 2);
            end
        end
    endtask

    // One selection: nw words from mo_a/tx_a, the last one cut to last_bits bits.
    task automatic burst(input int nw, input int last_bits);
        int           nb;
        logic [N-1:0] mi;
        tx_data = tx_a[0];
        cs_n    = 1'b0;
        #HALF;
        for (int w = 0; w < nw; w++) begin
            nb = (w == nw - 1) ? last_bits : N;
            xfer_word(mo_a[w], (w + 1 < nw) ? tx_a[w + 1] : tx_a[w], nb, mi);
            if (nb > 0) exp_tk++;
            if (nb == N) begin
                exp_rx = mo_a[w];
                exp_rxc++;
                last_mi = mi;
                check("master_rx", {24'd0, mi}, {24'd0, tx_a[w]});
            end
            check_state("word");
        end
        #HALF;
        cs_n = 1'b1;
        #HALF;
        check_state("deselect");
    endtask

    initial begin
        logic [N-1:0] mi;
        int           nw;
        int           cut;
        cs_n      = 1'b1;
        reset     = 1'b0;
        sclk      = 1'b0;
        cpol      = 1'b0;
        cpha      = 1'b0;
        lsb_first = 1'b0;
        mosi      = 1'b0;
        tx_data   = '0;
        #12;
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
        check("reset_rx_tgl", {31'd0, rx_tgl}, 32'd0);
        check("reset_tx_taken", {31'd0, tx_taken_tgl}, 32'd0);
        check("reset_miso", {31'd0, miso}, 32'd0);
        check("reset_miso_oe", {31'd0, miso_oe}, 32'd0);
        #3;
        reset = 1'b1;
        #5;

        // Mode 0 MSB, pinned against literal values.
        set_mode(1'b0, 1'b0, 1'b0);
        mo_a[0] = 8'hA5;
        tx_a[0] = 8'h7B;
        burst(1, N);
        check("t1_rx_lit", {24'd0, rx_data}, 32'hA5);
        check("t1_master_lit", {24'd0, last_mi}, 32'h7B);
        check("t1_rx_tgl_lit", {31'd0, rx_tgl}, 32'd1);
        check("t1_taken_lit", {31'd0, tx_taken_tgl}, 32'd1);

        // Modes 1..3 MSB.
        for (int m = 1; m < 4; m++) begin
            set_mode(m[1], m[0], 1'b0);
            mo_a[0] = t2_mo[m - 1];
            tx_a[0] = t2_tx[m - 1];
            burst(1, N);
        end

        // All modes LSB-first.
        for (int m = 0; m < 4; m++) begin
            set_mode(m[1], m[0], 1'b1);
            mo_a[0] = t3_mo[m];
            tx_a[0] = t3_tx[m];
            burst(1, N);
        end
        check("t3_rx_lit", {24'd0, rx_data}, 32'h48);
        check("t3_master_lit", {24'd0, last_mi}, 32'h21);

        // Two-word burst, tx_data swapped after the first take.
        set_mode(1'b0, 1'b0, 1'b0);
        mo_a[0] = 8'h11;
        mo_a[1] = 8'h22;
        tx_a[0] = 8'hAA;
        tx_a[1] = 8'h55;
        burst(2, N);
        check("t4_rx_lit", {24'd0, rx_data}, 32'h22);
        check("t4_master_lit", {24'd0, last_mi}, 32'h55);

        // Abort after 5 bits, then a full word.
        mo_a[0] = 8'hC3;
        tx_a[0] = 8'h5A;
        burst(1, 5);
        check("t5_abort_rx_lit", {24'd0, rx_data}, 32'h22);
        mo_a[0] = 8'h96;
        tx_a[0] = 8'h69;
        burst(1, N);
        check("t5_rx_lit", {24'd0, rx_data}, 32'h96);

        // Reset mid-word with the slave still selected.
        set_mode(1'b1, 1'b1, 1'b0);
        tx_data = 8'hC3;
        cs_n    = 1'b0;
        #HALF;
        xfer_word(8'h3C, 8'hC3, 4, mi);
        #5;
        reset = 1'b0;
        #2;
        check("t6_rx_data", {24'd0, rx_data}, 32'd0);
        check("t6_rx_tgl", {31'd0, rx_tgl}, 32'd0);
        check("t6_tx_taken", {31'd0, tx_taken_tgl}, 32'd0);
        check("t6_miso", {31'd0, miso}, 32'd0);
        check("t6_miso_oe", {31'd0, miso_oe}, 32'd0);
        #3;
        cs_n = 1'b1;
        #5;
        reset = 1'b1;
        #5;
        exp_rx  = '0;
        exp_rxc = 0;
        exp_tk  = 0;
        mo_a[0] = 8'h5A;
        tx_a[0] = 8'hA5;
        burst(1, N);
        check("t6_after_rx_lit", {24'd0, rx_data}, 32'h5A);

        // Randomized selections: random mode, order, length and occasional abort.
        for (int it = 0; it < 40; it++) begin
            set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
            nw = $urandom_range(1, 3);
            for (int w = 0; w < 4; w++) begin
                mo_a[w] = N'($urandom);
                tx_a[w] = N'($urandom);
            end
            cut = ($urandom_range(0, 3) == 0) ? $urandom_range(1, N - 1) : N;
            burst(nw, cut);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
